// File: rtl/arbiter_types.sv
// Shared enums for the I/D line-port arbiter.
// Kept apart from the core instruction types; only the arbiter imports these.
// No ports: type definitions only.
package arbiter_types;

  // FSM states: one transaction in flight at a time.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Who received the most recent grant; drives the round-robin tie break.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/cache_line_arbiter.sv
// Purpose: shares one physical-memory line port between the I-cache (read) and D-cache (read / write-back).
// Latency: request seen at edge n drives mem_read/mem_write in cycle n+1; resp is mem_resp passed through combinationally.
// Backpressure: requesters hold their request until resp; after every completion the FSM idles one cycle before the next grant.
// Ports: clk/rst (sync, active-low); i_* I-cache request/response; d_* D-cache request/response;
//        mem_* strobes, latched address/write line out, read data and completion in.
module cache_line_arbiter
  import arbiter_types::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // Memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t  state, state_nxt;
  arb_grant_t  last_grant, last_grant_nxt;
  logic              read_nxt, write_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic [LINE_W-1:0] wdata_nxt;

  logic i_req, d_req, pick_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  // D wins when alone, or on a tie when I held the previous grant.
  // last_grant resets to I, so the first tie after reset goes to D.
  assign pick_d = d_req & (~i_req | (last_grant == GRANT_I));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      mem_read    <= read_nxt;
      mem_write   <= write_nxt;
      mem_address <= address_nxt;
      mem_wdata   <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    read_nxt       = mem_read;
    write_nxt      = mem_write;
    address_nxt    = mem_address;
    wdata_nxt      = mem_wdata;
    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          if (pick_d) begin
            state_nxt      = SERVE_D;
            last_grant_nxt = GRANT_D;
            address_nxt    = d_address;
            wdata_nxt      = d_wdata;
            // Illegal read+write together resolves as a write-back.
            write_nxt      = d_write;
            read_nxt       = d_read & ~d_write;
          end else begin
            state_nxt      = SERVE_I;
            last_grant_nxt = GRANT_I;
            address_nxt    = i_address;
            write_nxt      = 1'b0;
            read_nxt       = 1'b1;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        // Requester inputs are ignored here; only memory completion ends service.
        if (mem_resp) begin
          state_nxt = IDLE;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
      end
    endcase
  end

  // Completion is steered only to the requester currently being served;
  // mem_resp in IDLE (e.g. after a reset abort) reaches nobody.
  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_line_arbiter.sv
module tb_cache_line_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, mem_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata, mem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic              i_resp, d_resp, mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;

  cache_line_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: is a transfer open, whose is it, what was latched.
  bit              m_busy, m_owner_d, m_last_d, m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  // Stimulus-agent state.
  bit i_pend, d_pend, d_kr, d_kw;
  int lat;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("mem_read",    LINE_W'(mem_read),    LINE_W'(m_busy && !m_wr));
    chk("mem_write",   LINE_W'(mem_write),   LINE_W'(m_busy && m_wr));
    chk("mem_address", LINE_W'(mem_address), LINE_W'(m_addr));
    chk("mem_wdata",   mem_wdata,            m_wdata);
    chk("i_resp",      LINE_W'(i_resp),      LINE_W'(m_busy && !m_owner_d && mem_resp));
    chk("d_resp",      LINE_W'(d_resp),      LINE_W'(m_busy && m_owner_d && mem_resp));
    chk("i_rdata",     i_rdata,              mem_rdata);
    chk("d_rdata",     d_rdata,              mem_rdata);
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_step();
    bit want_i, want_d, pick_d;
    if (!rst) begin
      m_busy = 0; m_last_d = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      i_pend = 0; d_pend = 0;
    end else if (m_busy) begin
      if (mem_resp) begin
        m_busy = 0;
        if (m_owner_d) d_pend = 0; else i_pend = 0;
      end
    end else begin
      want_i = i_read;
      want_d = d_read || d_write;
      if (want_i || want_d) begin
        // Alternate on ties: whoever did not go last goes now.
        pick_d    = want_d && (!want_i || !m_last_d);
        m_busy    = 1;
        m_owner_d = pick_d;
        m_last_d  = pick_d;
        lat       = $urandom_range(0, 4);
        if (pick_d) begin
          m_addr = d_address; m_wdata = d_wdata; m_wr = d_write;
        end else begin
          m_addr = i_address; m_wr = 0;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a5, pat_5a;
    logic [ADDR_W-1:0] exp_addr;
    int k;
    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};
    rst = 0; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    model_step();
    @(negedge clk);

    // Reset held, then idle.
    tick(); tick();
    rst = 1;
    for (int c = 0; c < 10; c++) tick();
    #1;
    chk("idle_mem_read",  LINE_W'(mem_read),  '0);
    chk("idle_mem_write", LINE_W'(mem_write), '0);

    // Lone I read, memory answers in the third strobe cycle.
    i_read = 1; i_address = 32'h0000_0060;
    tick();
    #1;
    chk("lone_strobe", LINE_W'(mem_read), LINE_W'(1));
    chk("lone_addr",   LINE_W'(mem_address), LINE_W'(32'h60));
    tick(); tick();
    mem_resp = 1; mem_rdata = pat_a5;
    #1;
    chk("lone_i_resp", LINE_W'(i_resp), LINE_W'(1));
    chk("lone_i_rdata", i_rdata, pat_a5);
    chk("lone_d_resp", LINE_W'(d_resp), '0);
    tick();
    i_read = 0; mem_resp = 0;
    #1;
    chk("lone_after_strobe", LINE_W'(mem_read), '0);
    tick();

    // Tie after reset: D first, one idle cycle, then I.
    rst = 0; tick(); rst = 1;
    i_read = 1; i_address = 32'h80;
    d_write = 1; d_address = 32'h100; d_wdata = pat_5a;
    tick();
    #1;
    chk("tie_d_write", LINE_W'(mem_write), LINE_W'(1));
    chk("tie_d_read",  LINE_W'(mem_read), '0);
    chk("tie_d_addr",  LINE_W'(mem_address), LINE_W'(32'h100));
    chk("tie_d_wdata", mem_wdata, pat_5a);
    chk("model_wdata", m_wdata, pat_5a);
    mem_resp = 1;
    #1;
    chk("tie_d_resp", LINE_W'(d_resp), LINE_W'(1));
    tick();
    d_write = 0; mem_resp = 0;
    #1;
    chk("tie_gap", LINE_W'(mem_read | mem_write), '0);
    tick();
    #1;
    chk("tie_i_next", LINE_W'(mem_read), LINE_W'(1));
    chk("tie_i_addr", LINE_W'(mem_address), LINE_W'(32'h80));
    mem_resp = 1;
    tick();
    i_read = 0; mem_resp = 0;
    tick();

    // Sustained contention after reset: D,I,D,I,D,I with one idle between.
    rst = 0; tick(); rst = 1;
    i_read = 1; i_address = 32'h200; d_read = 1; d_address = 32'h300;
    for (int t = 0; t < 6; t++) begin
      tick();
      exp_addr = (t % 2 == 0) ? 32'h300 : 32'h200;
      #1;
      chk("rr_addr",   LINE_W'(mem_address), LINE_W'(exp_addr));
      chk("rr_strobe", LINE_W'(mem_read), LINE_W'(1));
      mem_resp = 1; mem_rdata = {8{$urandom()}};
      tick();
      mem_resp = 0;
      #1;
      chk("rr_gap", LINE_W'(mem_read), '0);
    end
    i_read = 0; d_read = 0;
    tick();

    // Illegal read+write, then early drop mid-service.
    d_read = 1; d_write = 1; d_address = 32'h400;
    tick();
    #1;
    chk("ill_write", LINE_W'(mem_write), LINE_W'(1));
    chk("ill_read",  LINE_W'(mem_read), '0);
    d_read = 0; d_write = 0;
    tick();
    #1;
    chk("drop_hold", LINE_W'(mem_write), LINE_W'(1));
    mem_resp = 1;
    #1;
    chk("drop_d_resp", LINE_W'(d_resp), LINE_W'(1));
    tick();
    mem_resp = 0;
    tick();

    // Reset during SERVE_I, then a stale mem_resp.
    i_read = 1; i_address = 32'h500;
    tick();
    #1;
    chk("abort_strobe", LINE_W'(mem_read), LINE_W'(1));
    i_read = 0; rst = 0;
    tick();
    rst = 1; mem_resp = 1;
    #1;
    chk("abort_i_resp",  LINE_W'(i_resp), '0);
    chk("abort_strobe0", LINE_W'(mem_read), '0);
    chk("abort_addr0",   LINE_W'(mem_address), '0);
    tick();
    mem_resp = 0;
    tick();

    // Randomised traffic against the model.
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) != 0);
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1; i_address = $urandom();
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; d_address = $urandom();
        for (int w = 0; w < 8; w++) d_wdata[w*32 +: 32] = $urandom();
        k = $urandom_range(0, 19);
        d_kw = (k < 9) || (k == 19);
        d_kr = (k >= 9);
      end
      i_read  = i_pend;
      d_read  = d_pend && d_kr;
      d_write = d_pend && d_kw;
      // Occasionally drop a request while it is being served.
      if (m_busy && $urandom_range(0, 7) == 0) begin
        if (m_owner_d) begin d_read = 0; d_write = 0; end
        else i_read = 0;
      end
      for (int w = 0; w < 8; w++) mem_rdata[w*32 +: 32] = $urandom();
      if (m_busy) begin
        if (lat == 0) mem_resp = 1;
        else begin mem_resp = 0; lat--; end
      end else begin
        mem_resp = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_line_arbiter.md
Name: cache_line_arbiter

Overview:
- Arbitrates the single shared physical-memory line port between the instruction cache (read-only) and the data cache (read and write-back) of the pipelined rv32i core.
- Registered FSM: one transaction in flight at a time.
- Round-robin on simultaneous requests.
- Latches address and write data at grant; routes response and read data back to the granted requester only.

Parameters:
LINE_W, 256, cache line width in bits
ADDR_W, 32, line address width (low 5 bits are don't-care to the arbiter; passed through unchanged)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
i_read  in  1  I-cache line read request; held until i_resp
i_address  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line data to I-cache
i_resp  out  1  one-cycle I-cache completion
d_read  in  1  D-cache line read request; held until d_resp
d_write  in  1  D-cache line write-back request; held until d_resp
d_address  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write-back line
d_rdata  out  LINE_W  line data to D-cache
d_resp  out  1  one-cycle D-cache completion
mem_read  out  1  memory read strobe; held until mem_resp
mem_write  out  1  memory write strobe; held until mem_resp
mem_address  out  ADDR_W  latched address
mem_wdata  out  LINE_W  latched write line
mem_rdata  in  LINE_W  memory read data, valid with mem_resp
mem_resp  in  1  one-cycle memory completion

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Extra register last_grant ∈ {I, D}.

Reset (rst low at clock edge):
- State goes to IDLE, last_grant = I.
- mem_read = 0, mem_write = 0, mem_address = 0, mem_wdata = 0.
- i_resp and d_resp are 0 in the following cycle.
- Reset asserted mid-transaction aborts it. No resp is issued. A mem_resp arriving afterwards is ignored.

IDLE, request sampling at the clock edge:
- Only i_read: go to SERVE_I. mem_address <= i_address, mem_read <= 1, mem_write <= 0, last_grant <= I.
- Only d_read or d_write: go to SERVE_D. mem_address <= d_address, mem_wdata <= d_wdata, mem_write <= d_write, mem_read <= d_read & ~d_write, last_grant <= D.
- d_read and d_write both high: illegal. Write wins.
- Both requesters pending: grant the requester opposite last_grant. The first tie after reset goes to D.
- No request: stay in IDLE with strobes 0.
- Grant latency: a request first visible in cycle n appears on mem_read/mem_write in cycle n+1.

SERVE_x:
- Strobes, mem_address and mem_wdata are held constant.
- Requester inputs are ignored, including a request dropped early. The transaction still completes.
- x_resp = mem_resp (combinational, gated by state).
- x_rdata = mem_rdata.
- The non-granted resp is 0.
- At the edge where mem_resp = 1: go to IDLE, strobes <= 0.
- No back-to-back grant: IDLE always lasts at least one cycle. This lets the requester deassert its request after resp.
- Minimum turnaround: request cycle n, mem_resp cycle m ≥ n+1, next grant visible cycle m+2.

Other rules:
- i_rdata and d_rdata mirror mem_rdata in all states. They are valid only with the matching resp.
- mem_resp while in IDLE is ignored.
- No timeout: a hung memory holds the FSM in SERVE_x indefinitely.
- Fairness: with both requesters continuously requesting, grants alternate I/D. Neither waits more than one full transaction.

Decomposition:
- Add arb_state_t (IDLE, SERVE_I, SERVE_D) and arb_grant_t (GRANT_I, GRANT_D) enums to a new arbiter_types package alongside the existing mux packages.
- Do not add them to the core instruction types package.
- No sub-module: the select logic is a few lines inside the FSM.

Test Plan:
- Reset then idle: hold rst low for 2 cycles, release, no requests for 10 cycles -> mem_read = mem_write = 0, i_resp = d_resp = 0 throughout.
- Lone I read: i_read = 1, i_address = 0x0000_0060 at cycle 5; memory responds 3 cycles after strobe with data 0xA5 repeated -> mem_read high cycles 6–8 with mem_address 0x60; i_resp pulses cycle 8 with i_rdata = 0xA5 repeated; d_resp stays 0.
- Tie after reset: i_read and d_write (d_address 0x100, d_wdata 0x5A repeated) both asserted cycle 3 -> D granted first (mem_write = 1, mem_wdata 0x5A repeated); after d_resp, one IDLE cycle; I granted next.
- Sustained contention: both requesters re-request immediately after each resp for 6 transactions -> grant order D, I, D, I, D, I; each grant separated by exactly one IDLE cycle.
- Illegal d_read & d_write together, plus early drop: assert both -> mem_write = 1, mem_read = 0. Drop d_write mid-service -> strobe stays high until mem_resp; d_resp still pulses.
- Reset mid-transaction: assert rst low while in SERVE_I, then drive mem_resp the next cycle -> strobes 0 and i_resp = 0 after reset; the late mem_resp produces no resp.
